// File: rtl/cond_unit.sv
// Conditional-execution stage for the multicycle ARM core.
// Captures the condition result once per instruction, owns the NZCV
// register, gates the decoder's write requests and sequences the two
// register-file writes of a long multiply (UMULL/SMULL).
module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       FpuW,
    input  logic       lmulFlag,
    input  logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       FpuWrite,
    output logic       LongHi,
    output logic       Busy,
    output logic [3:0] Flags,
    output logic       CondEx
);

    typedef enum logic {
        IDLE = 1'b0,
        HI   = 1'b1
    } lmul_state_t;

    lmul_state_t state_reg;
    logic        dec_reg;
    logic        cond_ex_reg;
    logic [3:0]  flags_reg;
    logic        cond_met;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        in_hi;
    logic        lmul_start;

    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    // Evaluate the ARM condition field against the current flag register
    always_comb begin
        cond_met = 1'b0;
        case (Cond)
            4'b0000: cond_met = flag_z;
            4'b0001: cond_met = ~flag_z;
            4'b0010: cond_met = flag_c;
            4'b0011: cond_met = ~flag_c;
            4'b0100: cond_met = flag_n;
            4'b0101: cond_met = ~flag_n;
            4'b0110: cond_met = flag_v;
            4'b0111: cond_met = ~flag_v;
            4'b1000: cond_met = flag_c & ~flag_z;
            4'b1001: cond_met = ~flag_c | flag_z;
            4'b1010: cond_met = (flag_n == flag_v);
            4'b1011: cond_met = (flag_n != flag_v);
            4'b1100: cond_met = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_met = flag_z | (flag_n != flag_v);
            4'b1110: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // The cycle after an instruction-register load is the decode cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_reg <= 1'b0;
        end else begin
            dec_reg <= IRWrite;
        end
    end

    // Latch the condition result at the end of the decode cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_reg <= 1'b0;
        end else if (dec_reg) begin
            cond_ex_reg <= cond_met;
        end
    end

    // NZCV update; the high-word cycle of a long multiply never touches flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg <= 4'b0000;
        end else if (cond_ex_reg && (state_reg == IDLE)) begin
            if (FlagW[1]) begin
                flags_reg[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_reg[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign lmul_start = RegW & lmulFlag & cond_ex_reg;

    // Long-multiply sequencer: low word in IDLE, forced high-word write in HI
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_reg <= lmul_start ? HI : IDLE;
                HI:      state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_hi = (state_reg == HI);

    // Enables are zero-latency; reset low masks them regardless of inputs
    assign PCWrite  = reset & (NextPC | (PCS & cond_ex_reg));
    assign MemWrite = reset & MemW & cond_ex_reg;
    assign FpuWrite = reset & FpuW & cond_ex_reg;
    assign RegWrite = reset & (in_hi | (RegW & cond_ex_reg));
    assign LongHi   = reset & in_hi;
    assign Busy     = reset & ~in_hi & lmul_start;
    assign Flags    = flags_reg;
    assign CondEx   = cond_ex_reg;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: per-scenario tasks push expected
// output vectors into a scoreboard and compare them when sampled.
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       FpuW;
    logic       lmulFlag;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       FpuWrite;
    logic       LongHi;
    logic       Busy;
    logic [3:0] Flags;
    logic       CondEx;

    int checks = 0;
    int errors = 0;

    // Expected vector layout: {PCWrite,RegWrite,MemWrite,FpuWrite,LongHi,Busy,CondEx,Flags[3:0]}
    typedef struct {
        string      tag;
        logic [10:0] outs;
    } exp_t;

    // Stimulus vector layout
    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       fpuw;
        logic       lmul;
        logic [1:0] fw;
        logic [3:0] cond;
        logic [3:0] alu;
    } stim_t;

    exp_t sb[$];

    cond_unit dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .FpuW     (FpuW),
        .lmulFlag (lmulFlag),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .FpuWrite (FpuWrite),
        .LongHi   (LongHi),
        .Busy     (Busy),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic irw, input logic npc, input logic pcs,
                                 input logic regw, input logic memw, input logic fpuw,
                                 input logic lmul, input logic [1:0] fw,
                                 input logic [3:0] cond, input logic [3:0] alu);
        stim_t s;
        s.irw = irw; s.npc = npc; s.pcs = pcs; s.regw = regw; s.memw = memw;
        s.fpuw = fpuw; s.lmul = lmul; s.fw = fw; s.cond = cond; s.alu = alu;
        return s;
    endfunction

    function automatic logic [10:0] ex(input logic pcw, input logic rw, input logic mw,
                                       input logic fw, input logic lh, input logic busy,
                                       input logic cex, input logic [3:0] fl);
        return {pcw, rw, mw, fw, lh, busy, cex, fl};
    endfunction

    function automatic logic [10:0] obs();
        return {PCWrite, RegWrite, MemWrite, FpuWrite, LongHi, Busy, CondEx, Flags};
    endfunction

    // Reference condition table written from the ARM definitions
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input stim_t s);
        IRWrite = s.irw; NextPC = s.npc; PCS = s.pcs; RegW = s.regw; MemW = s.memw;
        FpuW = s.fpuw; lmulFlag = s.lmul; FlagW = s.fw; Cond = s.cond; ALUFlags = s.alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [10:0] got;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                reset = 1'b1;
                apply(st(0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
                sb.push_back('{"reset_release", ex(1, 0, 0, 0, 0, 0, 0, 4'b0000)});
            end else begin
                apply(st(1, 1, 1, 1, 1, 1, 1, 2'b11, 4'hE, 4'hF));
                sb.push_back('{"reset_hold", ex(0, 0, 0, 0, 0, 0, 0, 4'b0000)});
            end
            #4;
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s step %0d got %b expected %b", e.tag, i, got, e.outs);
            end
            tick();
        end
    endtask

    task automatic test_adds_beq();
        stim_t s[6];
        logic [10:0] x[6];
        exp_t e;
        logic [10:0] got;
        s[0] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[0] = ex(1, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[1] = ex(0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = st(0, 0, 0, 1, 0, 1, 0, 2'b11, 4'hE, 4'h6); x[2] = ex(0, 1, 0, 1, 0, 0, 1, 4'b0000);
        s[3] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[3] = ex(1, 0, 0, 0, 0, 0, 1, 4'b0110);
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[4] = ex(0, 0, 0, 0, 0, 0, 1, 4'b0110);
        s[5] = st(0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[5] = ex(1, 0, 0, 0, 0, 0, 1, 4'b0110);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back('{"adds_beq", x[i]});
            #4;
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s step %0d got %b expected %b", e.tag, i, got, e.outs);
            end
            tick();
        end
    endtask

    task automatic test_strne();
        stim_t s[7];
        logic [10:0] x[7];
        exp_t e;
        logic [10:0] got;
        s[0] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[0] = ex(1, 0, 0, 0, 0, 0, 1, 4'b0110);
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[1] = ex(0, 0, 0, 0, 0, 0, 1, 4'b0110);
        s[2] = st(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'hE, 4'h4); x[2] = ex(0, 0, 0, 0, 0, 0, 1, 4'b0110);
        s[3] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h1, 4'h0); x[3] = ex(1, 0, 0, 0, 0, 0, 1, 4'b0100);
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h1, 4'h0); x[4] = ex(0, 0, 0, 0, 0, 0, 1, 4'b0100);
        s[5] = st(0, 0, 1, 1, 1, 1, 0, 2'b11, 4'h1, 4'hF); x[5] = ex(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[6] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h1, 4'h0); x[6] = ex(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            sb.push_back('{"strne", x[i]});
            #4;
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s step %0d got %b expected %b", e.tag, i, got, e.outs);
            end
            tick();
        end
    endtask

    task automatic test_umull();
        stim_t s[5];
        logic [10:0] x[5];
        exp_t e;
        logic [10:0] got;
        s[0] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[0] = ex(1, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[1] = ex(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[2] = st(0, 0, 0, 1, 0, 0, 1, 2'b11, 4'hE, 4'h8); x[2] = ex(0, 1, 0, 0, 0, 1, 1, 4'b0100);
        s[3] = st(0, 0, 0, 1, 0, 0, 1, 2'b11, 4'hE, 4'h1); x[3] = ex(0, 1, 0, 0, 1, 0, 1, 4'b1000);
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[4] = ex(0, 0, 0, 0, 0, 0, 1, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back('{"umull", x[i]});
            #4;
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s step %0d got %b expected %b", e.tag, i, got, e.outs);
            end
            tick();
        end
    endtask

    task automatic test_lmul_fail();
        stim_t s[7];
        logic [10:0] x[7];
        exp_t e;
        logic [10:0] got;
        s[0] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0); x[0] = ex(1, 0, 0, 0, 0, 0, 1, 4'b1000);
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0); x[1] = ex(0, 0, 0, 0, 0, 0, 1, 4'b1000);
        s[2] = st(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'hE, 4'h9); x[2] = ex(0, 0, 0, 0, 0, 0, 1, 4'b1000);
        s[3] = st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'hB, 4'h0); x[3] = ex(1, 0, 0, 0, 0, 0, 1, 4'b1001);
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hB, 4'h0); x[4] = ex(0, 0, 0, 0, 0, 0, 1, 4'b1001);
        s[5] = st(0, 0, 0, 1, 0, 0, 1, 2'b00, 4'hB, 4'h0); x[5] = ex(0, 0, 0, 0, 0, 0, 0, 4'b1001);
        s[6] = st(0, 0, 0, 1, 0, 0, 1, 2'b00, 4'hB, 4'h0); x[6] = ex(0, 0, 0, 0, 0, 0, 0, 4'b1001);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            sb.push_back('{"lmul_fail", x[i]});
            #4;
            got = obs();
            e = sb.pop_front();
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s step %0d got %b expected %b", e.tag, i, got, e.outs);
            end
            tick();
        end
    endtask

    task automatic test_cond_sweep();
        exp_t e;
        logic [10:0] got;
        logic [3:0] c4;
        logic [3:0] f4;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                c4 = 4'(c);
                f4 = 4'(f);
                apply(st(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
                tick();
                apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0));
                tick();
                apply(st(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'hE, f4));
                tick();
                apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, c4, 4'h0));
                tick();
                apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, c4, 4'h0));
                sb.push_back('{"cond_sweep", ex(0, 0, 0, 0, 0, 0, cond_model(c4, f4), f4)});
                #4;
                got = obs();
                e = sb.pop_front();
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL %s cond %h flags %b got %b expected %b", e.tag, c4, f4, got, e.outs);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_in_hi();
        exp_t e;
        logic [10:0] got;
        apply(st(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
        tick();
        apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0));
        tick();
        apply(st(0, 0, 0, 1, 0, 0, 1, 2'b00, 4'hE, 4'h0));
        sb.push_back('{"hi_enter", ex(0, 1, 0, 0, 0, 1, 1, 4'b1111)});
        sb.push_back('{"hi_state", ex(0, 1, 0, 0, 1, 0, 1, 4'b1111)});
        sb.push_back('{"hi_reset", ex(0, 0, 0, 0, 0, 0, 0, 4'b0000)});
        sb.push_back('{"hi_after", ex(0, 0, 0, 0, 0, 0, 0, 4'b0000)});
        #4;
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e.outs) begin
            errors++;
            $display("FAIL %s got %b expected %b", e.tag, got, e.outs);
        end
        tick();
        apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0));
        #4;
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e.outs) begin
            errors++;
            $display("FAIL %s got %b expected %b", e.tag, got, e.outs);
        end
        #1;
        reset = 1'b0;
        #1;
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e.outs) begin
            errors++;
            $display("FAIL %s got %b expected %b", e.tag, got, e.outs);
        end
        tick();
        reset = 1'b1;
        #4;
        got = obs();
        e = sb.pop_front();
        checks++;
        if (got !== e.outs) begin
            errors++;
            $display("FAIL %s got %b expected %b", e.tag, got, e.outs);
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        apply(st(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
        test_reset();
        test_adds_beq();
        test_strne();
        test_umull();
        test_lmul_fail();
        test_cond_sweep();
        test_reset_in_hi();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d leftover entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage sitting directly downstream of the instruction decoder in the multicycle ARM core. Latches each instruction's condition result once per instruction, owns the NZCV flag register, and turns the decoder's raw write requests into the gated enables consumed by the PC, register file, data memory and FPU register file. Also sequences the two register-file writes of UMULL/SMULL and stalls the main FSM for one extra cycle.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  in  2  [1]: update N,Z; [0]: update C,V
- PCS  in  1  instruction writes PC (branch or Rd==15)
- NextPC  in  1  unconditional PC+4 update (fetch)
- RegW  in  1  register-file write request
- MemW  in  1  data-memory write request
- FpuW  in  1  FPU register write request
- lmulFlag  in  1  current instruction is a long multiply (two destination writes)
- IRWrite  in  1  instruction register loads this cycle (fetch)
- PCWrite  out  1  gated PC enable
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- FpuWrite  out  1  gated FPU write enable
- LongHi  out  1  0: write RdLo/low product word; 1: write RdHi/high word
- Busy  out  1  main FSM must hold its current state this cycle
- Flags  out  4  current {N,Z,C,V} register contents
- CondEx  out  1  registered condition result of the current instruction

## Operation
- Condition evaluation (combinational, on Cond and Flags register): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
- Decode tracking: internal bit dec set on cycle with IRWrite=1, cleared next cycle. On the edge ending a cycle with dec=1, CondEx <= evaluated condition. CondEx otherwise held until the next decode cycle.
- Flag update: on edge, if CondEx=1: FlagW[1] loads N,Z from ALUFlags[3:2]; FlagW[0] loads C,V from ALUFlags[1:0]. CondEx=0 -> Flags unchanged.
- Gated enables: PCWrite = NextPC | (PCS & CondEx); MemWrite = MemW & CondEx; FpuWrite = FpuW & CondEx; RegWrite per long-multiply FSM below.
- Long-multiply FSM, states IDLE, HI:
  - IDLE: RegWrite = RegW & CondEx; LongHi=0. If RegW & lmulFlag & CondEx: Busy=1, next HI. Else Busy=0, stay.
  - HI: RegWrite=1, LongHi=1, Busy=0; FlagW and RegW inputs ignored (no flag update); next IDLE unconditionally.
  - lmulFlag with CondEx=0: no writes, Busy=0, stay IDLE.
- Flags for a flag-setting long multiply update only in the IDLE (low-word) cycle.

## Timing
- Reset (low): Flags=0000, CondEx=0, dec=0, state IDLE; PCWrite, RegWrite, MemWrite, FpuWrite, Busy, LongHi forced 0 while reset low, regardless of inputs.
- First instruction after reset: CondEx valid from the cycle after its decode cycle; PCWrite=NextPC during fetch.
- Enables are combinational on inputs and registered CondEx/state; zero-cycle latency.
- Flags and CondEx update one edge after the qualifying cycle; condition evaluation in a decode cycle sees flags written by the previous instruction's final cycle.
- IRWrite in the same cycle as a flag update: flags update uses the old CondEx; new CondEx captured one cycle later.
- IRWrite asserted while in HI: illegal (FSM holds on Busy); behaviour unspecified, not required to be checked.
- Reset asserted in HI: return to IDLE immediately, LongHi=0.

## Test plan
- Reset low with RegW=MemW=NextPC=1 -> all enables 0, Flags=0000; release -> NextPC=1 gives PCWrite=1.
- ADDS (Cond=1110, FlagW=11, ALUFlags=0110) -> Flags=0110 next edge; following BEQ (Cond=0000, PCS=1) -> CondEx=1, PCWrite=1.
- Flags=0100, STRNE (Cond=0001, MemW=1) -> CondEx=0, MemWrite=0, subsequent FlagW=11 leaves Flags=0100.
- UMULL (Cond=1110, RegW=1, lmulFlag=1) -> cycle N: RegWrite=1, LongHi=0, Busy=1; N+1: RegWrite=1, LongHi=1, Busy=0; N+2 IDLE.
- Conditional long multiply failing (Cond=1011, Flags N=V) -> RegWrite=0 both cycles, Busy=0.
- Sweep all 16 Cond values against all 16 Flags values -> CondEx matches table; reset pulse during HI -> LongHi=0, IDLE.
